hi6110_rt_msg_assembler: RTL and testbench

//   Downstream stage of the HI-6110 RT receive-FIFO poller. Takes each 16-bit word read from the

---
 rtl/hi6110_rt_msg_assembler.sv | 234 +++++++++++++++++++++++
 tb/tb_hi6110_rt_msg_assembler.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hi6110_rt_msg_assembler.sv
// HI-6110 RT receive-word assembler: parses 1553 commands, buffers whole messages in a word FIFO
// behind tentative/committed write pointers, and serialises committed words as framed bytes.
module hi6110_rt_msg_assembler #(
    parameter int         DEPTH   = 64,
    parameter int         AW      = 6,
    parameter logic [4:0] RT_ADDR = 5'd1,
    parameter int         GAP_CYC = 2500
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rx_vld,
    input  logic [15:0] rx_word,
    output logic [7:0]  out_data,
    output logic        out_vld,
    input  logic        out_rdy,
    output logic        out_sof,
    output logic        out_eof,
    output logic [15:0] msg_cnt,
    output logic [7:0]  err_cnt,
    output logic        busy
);
    localparam int GW = $clog2(GAP_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_DISCARD} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [17:0]   r_mem [DEPTH];
    logic [AW:0]   r_wr_tent;
    logic [AW:0]   r_wr_cmt;
    logic [AW:0]   r_rd_ptr;
    logic [AW:0]   r_fetch_ptr;
    logic [5:0]    r_remain;
    logic [GW-1:0] r_gap;
    logic [17:0]   r_mq;
    logic [17:0]   r_ow;
    logic          r_mq_vld;
    logic          r_ov;
    logic          r_half;
    logic [15:0]   r_msg_cnt;
    logic [7:0]    r_err_cnt;

    logic [4:0]    w_rt;
    logic [4:0]    w_sa;
    logic [4:0]    w_wc;
    logic          w_tr;
    logic          w_addr_ok;
    logic          w_mode_code;
    logic [5:0]    w_expected;
    logic          w_full;
    logic          w_gap_hit;
    logic          w_we;
    logic          w_wsof;
    logic          w_weof;
    logic          w_commit;
    logic          w_abort;
    logic          w_acc;
    logic          w_done;
    logic          w_load;
    logic          w_fetch;

    assign w_rt        = rx_word[15:11];
    assign w_tr        = rx_word[10];
    assign w_sa        = rx_word[9:5];
    assign w_wc        = rx_word[4:0];
    assign w_addr_ok   = (w_rt == RT_ADDR) || (w_rt == 5'd31);
    assign w_mode_code = (w_sa == 5'd0) || (w_sa == 5'd31);
    // rd_ptr only frees an entry once its low byte has left, so in-flight words still count as used
    assign w_full      = ((r_wr_tent - r_rd_ptr) == (AW + 1)'(DEPTH));
    assign w_gap_hit   = !rx_vld && (r_gap == GW'(GAP_CYC - 1));

    always_comb begin
        if (w_tr)
            w_expected = 6'd0;
        else if (w_mode_code)
            w_expected = w_wc[4] ? 6'd1 : 6'd0;
        else if (w_wc == 5'd0)
            w_expected = 6'd32;
        else
            w_expected = {1'b0, w_wc};
    end

    always_ff @(posedge clk) begin
        if (!rstn)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (rx_vld && w_addr_ok) begin
                    if (w_full)
                        w_state_next = S_DISCARD;
                    else if (w_expected != 6'd0)
                        w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (rx_vld) begin
                    if (w_full)
                        w_state_next = S_DISCARD;
                    else if (r_remain == 6'd1)
                        w_state_next = S_IDLE;
                end else if (w_gap_hit) begin
                    w_state_next = S_IDLE;
                end
            end
            S_DISCARD: begin
                if (w_gap_hit)
                    w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_we     = 1'b0;
        w_wsof   = 1'b0;
        w_weof   = 1'b0;
        w_commit = 1'b0;
        w_abort  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (rx_vld && w_addr_ok) begin
                    if (w_full) begin
                        w_abort = 1'b1;
                    end else begin
                        w_we     = 1'b1;
                        w_wsof   = 1'b1;
                        w_weof   = (w_expected == 6'd0);
                        w_commit = (w_expected == 6'd0);
                    end
                end
            end
            S_DATA: begin
                if (rx_vld) begin
                    if (w_full) begin
                        w_abort = 1'b1;
                    end else begin
                        w_we     = 1'b1;
                        w_weof   = (r_remain == 6'd1);
                        w_commit = (r_remain == 6'd1);
                    end
                end else if (w_gap_hit) begin
                    w_abort = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Reader: two-stage pipe (RAM read register, then byte-serialising output word)
    assign w_acc   = r_ov && out_rdy;
    assign w_done  = w_acc && r_half;
    assign w_load  = r_mq_vld && (!r_ov || w_done);
    assign w_fetch = (r_fetch_ptr != r_wr_cmt) && (!r_mq_vld || w_load);

    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[r_wr_tent[AW-1:0]] <= {w_wsof, w_weof, rx_word};
        if (w_fetch)
            r_mq <= r_mem[r_fetch_ptr[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_tent   <= '0;
            r_wr_cmt    <= '0;
            r_rd_ptr    <= '0;
            r_fetch_ptr <= '0;
            r_remain    <= '0;
            r_gap       <= '0;
            r_mq_vld    <= 1'b0;
            r_ow        <= '0;
            r_ov        <= 1'b0;
            r_half      <= 1'b0;
            r_msg_cnt   <= '0;
            r_err_cnt   <= '0;
        end else begin
            if (w_abort)
                r_wr_tent <= r_wr_cmt;
            else if (w_we)
                r_wr_tent <= r_wr_tent + 1'b1;
            if (w_commit) begin
                r_wr_cmt  <= r_wr_tent + 1'b1;
                r_msg_cnt <= r_msg_cnt + 1'b1;
            end
            if (w_abort && (r_err_cnt != 8'hFF))
                r_err_cnt <= r_err_cnt + 1'b1;

            if (r_state == S_IDLE && w_we && !w_commit)
                r_remain <= w_expected;
            else if (r_state == S_DATA && w_we)
                r_remain <= r_remain - 1'b1;

            if (r_state == S_IDLE || rx_vld || w_state_next != r_state)
                r_gap <= '0;
            else
                r_gap <= r_gap + 1'b1;

            if (w_fetch) begin
                r_fetch_ptr <= r_fetch_ptr + 1'b1;
                r_mq_vld    <= 1'b1;
            end else if (w_load) begin
                r_mq_vld    <= 1'b0;
            end

            if (w_load) begin
                r_ow   <= r_mq;
                r_ov   <= 1'b1;
                r_half <= 1'b0;
            end else if (w_done) begin
                r_ov   <= 1'b0;
                r_half <= 1'b0;
            end else if (w_acc) begin
                r_half <= 1'b1;
            end
            if (w_done)
                r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    assign out_vld  = r_ov;
    assign out_data = r_half ? r_ow[7:0] : r_ow[15:8];
    assign out_sof  = r_ov && !r_half && r_ow[17];
    assign out_eof  = r_ov && r_half && r_ow[16];
    assign msg_cnt  = r_msg_cnt;
    assign err_cnt  = r_err_cnt;
    assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_hi6110_rt_msg_assembler.sv
// Bench for hi6110_rt_msg_assembler: directed literal scenarios plus randomized traffic checked
// every cycle against a message-level queue model.
module tb_hi6110_rt_msg_assembler;
    localparam int G     = 64;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        rx_vld = 1'b0;
    logic [15:0] rx_word = 16'h0;
    logic        out_rdy = 1'b0;
    logic [7:0]  out_data;
    logic        out_vld;
    logic        out_sof;
    logic        out_eof;
    logic [15:0] msg_cnt;
    logic [7:0]  err_cnt;
    logic        busy;

    hi6110_rt_msg_assembler #(.DEPTH(DEPTH), .AW(6), .RT_ADDR(5'd1), .GAP_CYC(G)) u_dut (
        .clk(clk), .rstn(rstn), .rx_vld(rx_vld), .rx_word(rx_word),
        .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy),
        .out_sof(out_sof), .out_eof(out_eof),
        .msg_cnt(msg_cnt), .err_cnt(err_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_mode = 0;        // 0 waiting for command, 1 collecting data, 2 discarding
    int          m_rem = 0;
    int          m_gap = 0;
    int          m_outstanding = 0; // committed words whose low byte has not left yet
    int          m_msg = 0;
    int          m_err = 0;
    logic [17:0] m_tent[$];
    logic [10:0] m_bytes[$];        // {is_low, sof, eof, data}
    logic [9:0]  cap[$];            // {sof, eof, data} of accepted bytes
    int          cap_cyc[$];
    int          ncyc = 0;
    bit          chk_en = 0;
    logic [10:0] b;

    function automatic int exp_words(input logic [15:0] w);
        if (w[10]) return 0;
        if (w[9:5] == 5'd0 || w[9:5] == 5'd31) return w[4] ? 1 : 0;
        if (w[4:0] == 5'd0) return 32;
        return int'(w[4:0]);
    endfunction

    task automatic m_commit();
        foreach (m_tent[i]) begin
            m_bytes.push_back({1'b0, m_tent[i][17], 1'b0, m_tent[i][15:8]});
            m_bytes.push_back({1'b1, 1'b0, m_tent[i][16], m_tent[i][7:0]});
        end
        m_outstanding += m_tent.size();
        m_tent.delete();
        m_msg = (m_msg + 1) & 16'hFFFF;
    endtask

    task automatic m_abort();
        m_tent.delete();
        if (m_err < 255) m_err++;
    endtask

    task automatic m_step_rx();
        int occ;
        int n;
        occ = m_outstanding + m_tent.size();
        if (m_mode == 0) begin
            if (rx_vld && (rx_word[15:11] == 5'd1 || rx_word[15:11] == 5'd31)) begin
                if (occ == DEPTH) begin
                    m_abort();
                    m_mode = 2;
                    m_gap  = 0;
                end else begin
                    n = exp_words(rx_word);
                    m_tent.push_back({1'b1, (n == 0), rx_word});
                    if (n == 0) m_commit();
                    else begin
                        m_mode = 1;
                        m_rem  = n;
                        m_gap  = 0;
                    end
                end
            end
        end else if (m_mode == 1) begin
            if (rx_vld) begin
                m_gap = 0;
                if (occ == DEPTH) begin
                    m_abort();
                    m_mode = 2;
                end else begin
                    m_tent.push_back({1'b0, (m_rem == 1), rx_word});
                    m_rem--;
                    if (m_rem == 0) begin
                        m_commit();
                        m_mode = 0;
                    end
                end
            end else begin
                m_gap++;
                if (m_gap == G) begin
                    m_abort();
                    m_mode = 0;
                end
            end
        end else begin
            if (rx_vld) m_gap = 0;
            else begin
                m_gap++;
                if (m_gap == G) m_mode = 0;
            end
        end
    endtask

    // Compare process: state seen now vs model, then advance the model over the coming edge
    always @(negedge clk) begin
        ncyc++;
        if (chk_en) begin
            chk("msg_cnt", {16'h0, msg_cnt}, m_msg);
            chk("err_cnt", {24'h0, err_cnt}, m_err);
            chk("busy", {31'h0, busy}, {31'h0, (m_mode != 0)});
            if (m_bytes.size() == 0) chk("spurious_out_vld", {31'h0, out_vld}, 32'h0);
            if (!rstn) begin
                m_mode = 0; m_rem = 0; m_gap = 0; m_outstanding = 0;
                m_msg = 0; m_err = 0;
                m_tent.delete();
                m_bytes.delete();
            end else begin
                m_step_rx();
                if (out_vld && out_rdy && m_bytes.size() != 0) begin
                    b = m_bytes.pop_front();
                    chk("out_byte", {22'h0, out_sof, out_eof, out_data}, {22'h0, b[9:0]});
                    if (b[10]) m_outstanding--;
                    cap.push_back({out_sof, out_eof, out_data});
                    cap_cyc.push_back(ncyc);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    bit rnd_rdy = 0;
    int rdy_pct = 100;

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_rdy) out_rdy = ($urandom_range(0, 99) < rdy_pct);
    endtask

    task automatic send(input logic [15:0] w);
        rx_vld  = 1'b1;
        rx_word = w;
        tick();
        rx_vld  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        cap.delete();
        cap_cyc.delete();
    endtask

    task automatic wait_bytes(input string name, input int n, input int budget);
        int k;
        k = 0;
        while (cap.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk({name, "_byte_count"}, cap.size(), n);
    endtask

    task automatic expect_bytes(input string name, input logic [9:0] e[$]);
        chk({name, "_len"}, cap.size(), e.size());
        foreach (e[i])
            if (i < cap.size()) chk($sformatf("%s_b%0d", name, i), {22'h0, cap[i]}, {22'h0, e[i]});
    endtask

    logic [9:0] e[$];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        tick();
        chk_en = 1;

        // Reset values
        do_reset();
        chk("rst_out_vld", {31'h0, out_vld}, 0);
        chk("rst_out_data", {24'h0, out_data}, 0);
        chk("rst_sof_eof", {30'h0, out_sof, out_eof}, 0);
        chk("rst_msg_cnt", {16'h0, msg_cnt}, 0);
        chk("rst_err_cnt", {24'h0, err_cnt}, 0);
        chk("rst_busy", {31'h0, busy}, 0);

        // 1: receive command with three data words
        out_rdy = 1'b1;
        send(16'h0823); send(16'h1111); send(16'h2222); send(16'h3333);
        wait_bytes("t1", 8, 50);
        e = '{10'h208, 10'h023, 10'h011, 10'h011, 10'h022, 10'h022, 10'h033, 10'h133};
        expect_bytes("t1", e);
        chk("t1_msg_cnt", {16'h0, msg_cnt}, 1);

        // 2: transmit command, then a foreign RT address
        cap.delete(); cap_cyc.delete();
        send(16'h0C22);
        wait_bytes("t2", 2, 50);
        e = '{10'h20C, 10'h122};
        expect_bytes("t2", e);
        cap.delete(); cap_cyc.delete();
        send(16'h1023);
        idle(10);
        chk("t2_foreign_bytes", cap.size(), 0);
        chk("t2_msg_cnt", {16'h0, msg_cnt}, 2);
        chk("t2_err_cnt", {24'h0, err_cnt}, 0);

        // 3: wc=0 means 32 words; continuous output; then broadcast
        do_reset();
        out_rdy = 1'b1;
        send(16'h0820);
        for (int i = 0; i < 32; i++) send(16'hD000 + 16'(i));
        wait_bytes("t3", 66, 300);
        e.delete();
        e.push_back(10'h208);
        e.push_back(10'h020);
        for (int i = 0; i < 32; i++) begin
            e.push_back(10'h0D0);
            e.push_back({1'b0, (i == 31), 8'(i)});
        end
        expect_bytes("t3", e);
        if (cap_cyc.size() >= 66) chk("t3_contiguous", cap_cyc[65] - cap_cyc[0], 65);
        cap.delete(); cap_cyc.delete();
        send(16'hF823); send(16'h4444); send(16'h5555); send(16'h6666);
        wait_bytes("t3b", 8, 50);
        e = '{10'h2F8, 10'h023, 10'h044, 10'h044, 10'h055, 10'h055, 10'h066, 10'h166};
        expect_bytes("t3b", e);
        chk("t3_msg_cnt", {16'h0, msg_cnt}, 2);

        // 4: gap of G-1 survives, gap of exactly G aborts
        do_reset();
        out_rdy = 1'b1;
        send(16'h0822); idle(G - 1); send(16'h7777); idle(G - 1); send(16'h8888);
        wait_bytes("t4a", 6, 50);
        chk("t4a_err_cnt", {24'h0, err_cnt}, 0);
        cap.delete(); cap_cyc.delete();
        send(16'h0823); send(16'hAAAA);
        idle(G);
        chk("t4_err_cnt", {24'h0, err_cnt}, 1);
        chk("t4_busy", {31'h0, busy}, 0);
        chk("t4_no_bytes", cap.size(), 0);
        send(16'h0C22);
        wait_bytes("t4", 2, 50);
        idle(5);
        e = '{10'h20C, 10'h122};
        expect_bytes("t4", e);

        // 5: overflow while the output is stalled
        do_reset();
        out_rdy = 1'b0;
        send(16'h0820);
        for (int i = 0; i < 32; i++) send(16'h1000 + 16'(i));
        send(16'h0820);
        for (int i = 0; i < 31; i++) send(16'h2000 + 16'(i));
        chk("t5_err_cnt", {24'h0, err_cnt}, 1);
        chk("t5_msg_cnt", {16'h0, msg_cnt}, 1);
        idle(G + 2);
        out_rdy = 1'b1;
        wait_bytes("t5", 66, 300);
        idle(20);
        chk("t5_total", cap.size(), 66);
        if (cap.size() >= 66) chk("t5_last", {22'h0, cap[65]}, {22'h0, 10'h11F});

        // 6: reset mid-DATA and mid-serialisation
        do_reset();
        out_rdy = 1'b0;
        send(16'h0C22); send(16'h0823); send(16'h1111);
        idle(2);
        chk("t6_pre_vld", {31'h0, out_vld}, 1);
        do_reset();
        chk("t6_out_vld", {31'h0, out_vld}, 0);
        chk("t6_msg_cnt", {16'h0, msg_cnt}, 0);
        chk("t6_err_cnt", {24'h0, err_cnt}, 0);
        chk("t6_busy", {31'h0, busy}, 0);
        out_rdy = 1'b1;
        send(16'h0C22);
        wait_bytes("t6", 2, 50);
        idle(5);
        e = '{10'h20C, 10'h122};
        expect_bytes("t6", e);

        // Randomized traffic checked by the model
        do_reset();
        rnd_rdy = 1;
        for (int m = 0; m < 220; m++) begin
            logic [4:0]  rt;
            logic [4:0]  sa;
            logic [4:0]  wc;
            logic        tr;
            logic [15:0] cmd;
            int          n;
            int          sendn;
            if (m < 60) rdy_pct = 80;
            else if (m < 120) rdy_pct = 3;
            else if (m < 170) rdy_pct = 100;
            else rdy_pct = 50;
            rt = ($urandom_range(0, 9) == 0) ? 5'd2 : ($urandom_range(0, 1) ? 5'd1 : 5'd31);
            tr = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 7))
                0: sa = 5'd0;
                1: sa = 5'd31;
                default: sa = 5'($urandom_range(1, 30));
            endcase
            wc = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 6));
            cmd = {rt, tr, sa, wc};
            n = exp_words(cmd);
            sendn = n;
            if (n > 0 && $urandom_range(0, 9) == 0) sendn = $urandom_range(0, n - 1);
            send(cmd);
            for (int k = 0; k < sendn; k++) begin
                if ($urandom_range(0, 40) == 0) idle(G - 1);
                else idle($urandom_range(0, 2));
                send(16'($urandom));
            end
            if (sendn < n) idle(G + 3);
            idle($urandom_range(0, 3));
        end

        // Drain everything still committed
        rnd_rdy = 0;
        out_rdy = 1'b1;
        idle(G + 5);
        begin
            int k;
            k = 0;
            while (m_bytes.size() != 0 && k < 3000) begin
                tick();
                k++;
            end
        end
        chk("drain_remaining", m_bytes.size(), 0);
        idle(5);
        chk("drain_out_vld", {31'h0, out_vld}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
